// File: rtl/brief_descriptor_engine.sv
// BRIEF descriptor engine: walks a pattern ROM of pixel-pair addresses,
// reads both pixels of every pair from patch memory, and sets each
// descriptor bit when pixel A is strictly darker than pixel B.
//
// Pipeline (one word = LANES pairs):
//   cycle c   : pat_rd/pat_addr issue word w
//   cycle c+1 : pat_data valid, pix_rd with per-lane addresses
//   cycle c+2 : pix_data valid, comparison written into the shadow at c+3
// The FSM waits out the last two pipeline stages in DRAIN, so the final bit
// lands in the shadow on the same edge that the FSM enters OUT.
//
// Handshake: desc_valid/desc_ready is valid/ready. desc and desc_id are
// stable while desc_valid is high; the transfer happens on the rising edge
// where both are high, and desc_valid drops on the following cycle.
//
// Parameter constraint: DESC_BITS must be a multiple of LANES.
module brief_descriptor_engine #(
    parameter int PIX_W      = 8,
    parameter int PATCH_SIDE = 31,
    parameter int DESC_BITS  = 256,
    parameter int LANES      = 4,
    parameter int ID_W       = 16,
    localparam int AW        = $clog2(PATCH_SIDE * PATCH_SIDE),
    localparam int W         = DESC_BITS / LANES,
    localparam int PW        = (W > 1) ? $clog2(W) : 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic [ID_W-1:0]        i_kp_id,
    input  logic                   i_abort,
    output logic                   o_busy,
    output logic                   o_pat_rd,
    output logic [PW-1:0]          o_pat_addr,
    input  logic [LANES*2*AW-1:0]  i_pat_data,
    output logic                   o_pix_rd,
    output logic [LANES*AW-1:0]    o_pix_addr_a,
    output logic [LANES*AW-1:0]    o_pix_addr_b,
    input  logic [LANES*PIX_W-1:0] i_pix_data_a,
    input  logic [LANES*PIX_W-1:0] i_pix_data_b,
    output logic [DESC_BITS-1:0]   o_desc,
    output logic [ID_W-1:0]        o_desc_id,
    output logic                   o_desc_valid,
    input  logic                   i_desc_ready,
    output logic [1:0]             o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic                  r_pat_rd;
    logic [PW-1:0]         r_pat_addr;
    logic                  r_pix_rd;
    logic [PW-1:0]         r_pix_word;
    logic                  r_cmp_vld;
    logic [PW-1:0]         r_cmp_word;
    logic                  r_drain;
    logic [DESC_BITS-1:0]  r_desc;
    logic [ID_W-1:0]       r_desc_id;
    logic [LANES-1:0]      w_lt;

    assign o_pat_rd   = r_pat_rd;
    assign o_pat_addr = r_pat_addr;
    assign o_pix_rd   = r_pix_rd;
    assign o_desc     = r_desc;
    assign o_desc_id  = r_desc_id;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and state-decoded outputs; abort overrides everything.
    always_comb begin
        w_next_state = r_state;
        o_busy       = (r_state != S_IDLE);
        o_desc_valid = (r_state == S_OUT);
        o_dbg_state  = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (r_pat_rd && (r_pat_addr == PW'(W - 1))) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_drain) begin
                    w_next_state = S_OUT;
                end
            end
            S_OUT: begin
                if (i_desc_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
        if (i_abort) begin
            w_next_state = S_IDLE;
        end
    end

    // Patch addresses come straight from the ROM word while pix_rd is high.
    always_comb begin
        o_pix_addr_a = '0;
        o_pix_addr_b = '0;
        if (r_pix_rd) begin
            for (int j = 0; j < LANES; j++) begin
                o_pix_addr_a[j*AW +: AW] = i_pat_data[j*2*AW + AW +: AW];
                o_pix_addr_b[j*AW +: AW] = i_pat_data[j*2*AW +: AW];
            end
        end
    end

    // Per-lane unsigned strict comparison; equal pixels give 0.
    always_comb begin
        w_lt = '0;
        for (int j = 0; j < LANES; j++) begin
            w_lt[j] = (i_pix_data_a[j*PIX_W +: PIX_W] < i_pix_data_b[j*PIX_W +: PIX_W]);
        end
    end

    // Word counter, read strobes and the pipeline word tags.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pat_rd   <= 1'b0;
            r_pat_addr <= '0;
            r_pix_rd   <= 1'b0;
            r_pix_word <= '0;
            r_cmp_vld  <= 1'b0;
            r_cmp_word <= '0;
            r_drain    <= 1'b0;
            r_desc_id  <= '0;
        end else begin
            r_pix_rd   <= r_pat_rd && !i_abort;
            r_pix_word <= r_pat_addr;
            r_cmp_vld  <= r_pix_rd && !i_abort;
            r_cmp_word <= r_pix_word;
            r_drain    <= (r_state == S_DRAIN) && !i_abort;
            if (i_abort) begin
                r_pat_rd <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_pat_rd <= 1'b0;
                        if (i_start) begin
                            r_pat_addr <= '0;
                            r_desc_id  <= i_kp_id;
                        end
                    end
                    S_RUN: begin
                        // The counter parks on the last word instead of wrapping.
                        if (!r_pat_rd) begin
                            r_pat_rd <= 1'b1;
                        end else if (r_pat_addr == PW'(W - 1)) begin
                            r_pat_rd <= 1'b0;
                        end else begin
                            r_pat_addr <= r_pat_addr + PW'(1);
                        end
                    end
                    default: r_pat_rd <= 1'b0;
                endcase
            end
        end
    end

    // Shadow descriptor: each comparison lands at its absolute bit index.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_desc <= '0;
        end else if (r_cmp_vld && !i_abort) begin
            for (int w = 0; w < W; w++) begin
                if (r_cmp_word == PW'(w)) begin
                    for (int j = 0; j < LANES; j++) begin
                        r_desc[w*LANES + j] <= w_lt[j];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_brief_descriptor_engine.sv
// Self-checking bench for brief_descriptor_engine: a default-size instance
// with pattern ROM / patch memory models, plus two 8-bit descriptor
// instances (1 lane and 8 lanes) sharing one reduced pattern.
module tb_brief_descriptor_engine;

    localparam int PIX_W      = 8;
    localparam int PATCH_SIDE = 31;
    localparam int DESC_BITS  = 256;
    localparam int LANES      = 4;
    localparam int ID_W       = 16;
    localparam int AW         = 10;
    localparam int W          = DESC_BITS / LANES;
    localparam int PW         = 6;
    localparam int NPIX       = PATCH_SIDE * PATCH_SIDE;
    localparam int LAT        = W + 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- main instance ----------------
    logic                   start, abort, desc_ready;
    logic [ID_W-1:0]        kp_id;
    logic                   busy, pat_rd, pix_rd, desc_valid;
    logic [PW-1:0]          pat_addr;
    logic [LANES*2*AW-1:0]  pat_data;
    logic [LANES*AW-1:0]    pix_addr_a, pix_addr_b;
    logic [LANES*PIX_W-1:0] pix_data_a, pix_data_b;
    logic [DESC_BITS-1:0]   desc;
    logic [ID_W-1:0]        desc_id;
    logic [1:0]             dbg_state;

    brief_descriptor_engine u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_kp_id(kp_id), .i_abort(abort),
        .o_busy(busy), .o_pat_rd(pat_rd), .o_pat_addr(pat_addr), .i_pat_data(pat_data),
        .o_pix_rd(pix_rd), .o_pix_addr_a(pix_addr_a), .o_pix_addr_b(pix_addr_b),
        .i_pix_data_a(pix_data_a), .i_pix_data_b(pix_data_b),
        .o_desc(desc), .o_desc_id(desc_id), .o_desc_valid(desc_valid),
        .i_desc_ready(desc_ready), .o_dbg_state(dbg_state)
    );

    // Pattern ROM (entry k = {addr_a, addr_b} for descriptor bit k) and patch memory.
    logic [2*AW-1:0]  pat_mem [0:DESC_BITS-1];
    logic [PIX_W-1:0] pix_mem [0:NPIX-1];

    always @(posedge clk) begin
        if (pat_rd) begin
            for (int j = 0; j < LANES; j++) begin
                pat_data[j*2*AW +: 2*AW] <= pat_mem[int'(pat_addr)*LANES + j];
            end
        end
    end

    always @(posedge clk) begin
        if (pix_rd) begin
            for (int j = 0; j < LANES; j++) begin
                pix_data_a[j*PIX_W +: PIX_W] <= pix_mem[pix_addr_a[j*AW +: AW]];
                pix_data_b[j*PIX_W +: PIX_W] <= pix_mem[pix_addr_b[j*AW +: AW]];
            end
        end
    end

    // ---------------- reduced instances (8-bit descriptors) ----------------
    logic            s_start, s_abort, s_ready;
    logic [ID_W-1:0] s_kp_id;

    logic            s1_busy, s1_pat_rd, s1_pix_rd, s1_valid;
    logic [2:0]      s1_pat_addr;
    logic [19:0]     s1_pat_data;
    logic [9:0]      s1_paa, s1_pab;
    logic [7:0]      s1_pda, s1_pdb, s1_desc;
    logic [ID_W-1:0] s1_desc_id;
    logic [1:0]      s1_dbg;

    logic            s8_busy, s8_pat_rd, s8_pix_rd, s8_valid;
    logic [0:0]      s8_pat_addr;
    logic [159:0]    s8_pat_data;
    logic [79:0]     s8_paa, s8_pab;
    logic [63:0]     s8_pda, s8_pdb;
    logic [7:0]      s8_desc;
    logic [ID_W-1:0] s8_desc_id;
    logic [1:0]      s8_dbg;

    brief_descriptor_engine #(.DESC_BITS(8), .LANES(1)) u_dut_l1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(s_start), .i_kp_id(s_kp_id), .i_abort(s_abort),
        .o_busy(s1_busy), .o_pat_rd(s1_pat_rd), .o_pat_addr(s1_pat_addr), .i_pat_data(s1_pat_data),
        .o_pix_rd(s1_pix_rd), .o_pix_addr_a(s1_paa), .o_pix_addr_b(s1_pab),
        .i_pix_data_a(s1_pda), .i_pix_data_b(s1_pdb),
        .o_desc(s1_desc), .o_desc_id(s1_desc_id), .o_desc_valid(s1_valid),
        .i_desc_ready(s_ready), .o_dbg_state(s1_dbg)
    );

    brief_descriptor_engine #(.DESC_BITS(8), .LANES(8)) u_dut_l8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(s_start), .i_kp_id(s_kp_id), .i_abort(s_abort),
        .o_busy(s8_busy), .o_pat_rd(s8_pat_rd), .o_pat_addr(s8_pat_addr), .i_pat_data(s8_pat_data),
        .o_pix_rd(s8_pix_rd), .o_pix_addr_a(s8_paa), .o_pix_addr_b(s8_pab),
        .i_pix_data_a(s8_pda), .i_pix_data_b(s8_pdb),
        .o_desc(s8_desc), .o_desc_id(s8_desc_id), .o_desc_valid(s8_valid),
        .i_desc_ready(s_ready), .o_dbg_state(s8_dbg)
    );

    // Reduced pattern: pair k = (k, 100+k); only pixel 105 is brighter, so only pair 5 has a<b.
    function automatic logic [7:0] spix(input logic [9:0] a);
        return (a == 10'd105) ? 8'h90 : 8'h80;
    endfunction

    always @(posedge clk) begin
        if (s1_pat_rd) s1_pat_data <= {10'(s1_pat_addr), 10'(int'(s1_pat_addr) + 100)};
        if (s1_pix_rd) begin
            s1_pda <= spix(s1_paa);
            s1_pdb <= spix(s1_pab);
        end
        if (s8_pat_rd) begin
            for (int j = 0; j < 8; j++) s8_pat_data[j*20 +: 20] <= {10'(j), 10'(j + 100)};
        end
        if (s8_pix_rd) begin
            for (int j = 0; j < 8; j++) begin
                s8_pda[j*8 +: 8] <= spix(s8_paa[j*10 +: 10]);
                s8_pdb[j*8 +: 8] <= spix(s8_pab[j*10 +: 10]);
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [DESC_BITS-1:0] exp_q[$];
    logic [ID_W-1:0]      exp_id_q[$];
    logic [7:0]           exp_s_q[$];
    int total = 0;
    int bad   = 0;

    // Reference: bit k = pixel[a_k] < pixel[b_k], unsigned strict.
    function automatic logic [DESC_BITS-1:0] model_desc();
        logic [DESC_BITS-1:0] r;
        r = '0;
        for (int k = 0; k < DESC_BITS; k++) begin
            r[k] = (pix_mem[pat_mem[k][2*AW-1:AW]] < pix_mem[pat_mem[k][AW-1:0]]);
        end
        return r;
    endfunction

    // ---------------- stimulus setup ----------------
    // Pixel 256 wraps to 0, so pair 255 compares 255 < 0 and its bit is 0.
    task automatic setup_ramp();
        for (int i = 0; i < NPIX; i++) pix_mem[i] = 8'(i % 256);
        for (int k = 0; k < DESC_BITS; k++) pat_mem[k] = {10'(k), 10'(k + 1)};
    endtask

    task automatic setup_const();
        for (int i = 0; i < NPIX; i++) pix_mem[i] = 8'h55;
        for (int k = 0; k < DESC_BITS; k++) begin
            pat_mem[k] = {10'($urandom_range(0, NPIX - 1)), 10'($urandom_range(0, NPIX - 1))};
        end
    endtask

    task automatic setup_random(input int max_pix);
        for (int i = 0; i < NPIX; i++) pix_mem[i] = 8'($urandom_range(0, max_pix));
        for (int k = 0; k < DESC_BITS; k++) begin
            pat_mem[k] = {10'($urandom_range(0, NPIX - 1)), 10'($urandom_range(0, NPIX - 1))};
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_start(input logic [ID_W-1:0] id);
        @(negedge clk);
        start = 1'b1;
        kp_id = id;
        exp_q.push_back(model_desc());
        exp_id_q.push_back(id);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Returns cycles from the start edge to the edge after which desc_valid is seen.
    task automatic wait_valid(output int lat, output bit timed_out);
        int n;
        n = 0;
        lat = 0;
        timed_out = 1'b1;
        while (n < 200 && timed_out) begin
            @(posedge clk);
            #1 n++;
            if (desc_valid) begin
                lat = n;
                timed_out = 1'b0;
            end
        end
    endtask

    task automatic accept();
        @(negedge clk);
        desc_ready = 1'b1;
        @(posedge clk);
        #1 desc_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 total++;
        if ({busy, pat_rd, pix_rd, desc_valid} !== 4'b0 || pat_addr !== '0 || pix_addr_a !== '0 ||
            pix_addr_b !== '0 || desc !== '0 || desc_id !== '0) begin
            bad++;
            $display("FAIL reset_state: busy=%b pat_rd=%b pix_rd=%b valid=%b desc_id=%h want all 0",
                     busy, pat_rd, pix_rd, desc_valid, desc_id);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_ramp();
        int lat; bit to;
        logic [DESC_BITS-1:0] ed; logic [ID_W-1:0] ei;
        setup_ramp();
        drive_start(16'hA5C3);
        wait_valid(lat, to);
        total++;
        if (to || lat != LAT) begin bad++; $display("FAIL ramp_latency: got %0d want %0d", lat, LAT); end
        ed = exp_q.pop_front(); ei = exp_id_q.pop_front();
        total++;
        if (desc !== ed) begin bad++; $display("FAIL ramp_desc: got %h want %h", desc, ed); end
        total++;
        if (desc_id !== ei) begin bad++; $display("FAIL ramp_id: got %h want %h", desc_id, ei); end
        accept();
        total++;
        if (busy !== 1'b0 || desc_valid !== 1'b0) begin
            bad++; $display("FAIL ramp_release: busy=%b valid=%b want 0 0", busy, desc_valid);
        end
    endtask

    task automatic test_const();
        int lat; bit to;
        logic [DESC_BITS-1:0] ed; logic [ID_W-1:0] ei;
        setup_const();
        drive_start(16'h0055);
        wait_valid(lat, to);
        ed = exp_q.pop_front(); ei = exp_id_q.pop_front();
        total++;
        if (to || desc !== ed || desc_id !== ei) begin
            bad++; $display("FAIL const_desc: got %h id %h want %h id %h", desc, desc_id, ed, ei);
        end
        accept();
    endtask

    // Ready held high before valid: valid lasts exactly one cycle.
    task automatic test_random();
        int lat; bit to;
        logic [DESC_BITS-1:0] ed; logic [ID_W-1:0] ei;
        for (int r = 0; r < 2; r++) begin
            setup_random(r == 0 ? 3 : 255);
            desc_ready = 1'b1;
            drive_start(16'($urandom_range(0, 65535)));
            wait_valid(lat, to);
            ed = exp_q.pop_front(); ei = exp_id_q.pop_front();
            total++;
            if (to || lat != LAT || desc !== ed || desc_id !== ei) begin
                bad++;
                $display("FAIL random_%0d: lat %0d desc %h id %h want lat %0d desc %h id %h",
                         r, lat, desc, desc_id, LAT, ed, ei);
            end
            @(posedge clk);
            #1 total++;
            if (busy !== 1'b0 || desc_valid !== 1'b0) begin
                bad++; $display("FAIL random_%0d_release: busy=%b valid=%b want 0 0", r, busy, desc_valid);
            end
            desc_ready = 1'b0;
        end
    endtask

    task automatic test_stall();
        int lat; bit to;
        logic [DESC_BITS-1:0] ed; logic [ID_W-1:0] ei;
        setup_random(255);
        drive_start(16'h1234);
        wait_valid(lat, to);
        ed = exp_q.pop_front(); ei = exp_id_q.pop_front();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start = (i % 3 == 0);
            kp_id = 16'hDEAD;
            @(posedge clk);
            #1 total++;
            if ({desc_valid, busy, pat_rd, pix_rd} !== 4'b1100 || desc !== ed || desc_id !== ei) begin
                bad++;
                $display("FAIL stall_hold_%0d: valid=%b busy=%b pat_rd=%b pix_rd=%b id %h want 1 1 0 0 id %h",
                         i, desc_valid, busy, pat_rd, pix_rd, desc_id, ei);
            end
        end
        start = 1'b0;
        accept();
        total++;
        if (busy !== 1'b0 || desc_valid !== 1'b0) begin
            bad++; $display("FAIL stall_release: busy=%b valid=%b want 0 0", busy, desc_valid);
        end
        @(posedge clk);
        #1 total++;
        if (busy !== 1'b0 || desc !== ed || desc_id !== ei) begin
            bad++; $display("FAIL stall_after: busy=%b id %h want 0 id %h", busy, desc_id, ei);
        end
    endtask

    task automatic test_abort();
        int lat; bit to; bit seen;
        logic [DESC_BITS-1:0] ed; logic [ID_W-1:0] ei;
        setup_random(255);
        @(negedge clk);
        start = 1'b1;
        kp_id = 16'hBAD0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        start = 1'b1;
        desc_ready = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        start = 1'b0;
        desc_ready = 1'b0;
        total++;
        if ({pat_rd, pix_rd, busy} !== 3'b000) begin
            bad++; $display("FAIL abort_stop: pat_rd=%b pix_rd=%b busy=%b want 0 0 0", pat_rd, pix_rd, busy);
        end
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk);
            #1 if (desc_valid || busy) seen = 1'b1;
        end
        total++;
        if (seen) begin bad++; $display("FAIL abort_quiet: activity=1 want 0"); end
        setup_random(15);
        drive_start(16'hC0DE);
        wait_valid(lat, to);
        ed = exp_q.pop_front(); ei = exp_id_q.pop_front();
        total++;
        if (to || lat != LAT || desc !== ed || desc_id !== ei) begin
            bad++; $display("FAIL abort_next: lat %0d desc %h id %h want lat %0d desc %h id %h",
                            lat, desc, desc_id, LAT, ed, ei);
        end
        accept();
    endtask

    task automatic test_reset_mid();
        int lat; bit to;
        logic [DESC_BITS-1:0] ed; logic [ID_W-1:0] ei;
        // Reset during RUN, between clock edges.
        setup_ramp();
        @(negedge clk);
        start = 1'b1;
        kp_id = 16'h7777;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 total++;
        if ({busy, pat_rd, pix_rd, desc_valid} !== 4'b0 || pat_addr !== '0 || pix_addr_a !== '0 ||
            pix_addr_b !== '0 || desc !== '0 || desc_id !== '0) begin
            bad++; $display("FAIL reset_mid_run: busy=%b pat_rd=%b pix_rd=%b pat_addr=%0d want all 0",
                            busy, pat_rd, pix_rd, pat_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // Reset while a finished descriptor waits in OUT.
        drive_start(16'h4242);
        wait_valid(lat, to);
        void'(exp_q.pop_front());
        void'(exp_id_q.pop_front());
        #2 rst_n = 1'b0;
        #1 total++;
        if ({busy, pat_rd, pix_rd, desc_valid} !== 4'b0 || desc !== '0 || desc_id !== '0) begin
            bad++; $display("FAIL reset_mid_out: busy=%b valid=%b desc_id=%h want 0 0 0",
                            busy, desc_valid, desc_id);
        end
        // Start on the first edge after reset release.
        setup_random(255);
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        kp_id = 16'h9E5E;
        exp_q.push_back(model_desc());
        exp_id_q.push_back(16'h9E5E);
        @(posedge clk);
        #1 start = 1'b0;
        wait_valid(lat, to);
        ed = exp_q.pop_front(); ei = exp_id_q.pop_front();
        total++;
        if (to || lat != LAT || desc !== ed || desc_id !== ei) begin
            bad++; $display("FAIL reset_fresh: lat %0d desc %h id %h want lat %0d desc %h id %h",
                            lat, desc, desc_id, LAT, ed, ei);
        end
        accept();
    endtask

    task automatic test_back_to_back();
        int lat; bit to;
        logic [DESC_BITS-1:0] ed; logic [ID_W-1:0] ei;
        for (int r = 0; r < 3; r++) begin
            setup_random(r * 40 + 7);
            drive_start(16'($urandom_range(0, 65535)));
            wait_valid(lat, to);
            ed = exp_q.pop_front(); ei = exp_id_q.pop_front();
            total++;
            if (to || lat != LAT || desc !== ed || desc_id !== ei) begin
                bad++; $display("FAIL b2b_%0d: lat %0d desc %h id %h want lat %0d desc %h id %h",
                                r, lat, desc, desc_id, LAT, ed, ei);
            end
            accept();
        end
    endtask

    task automatic test_small_lanes();
        int lat1, lat8, n;
        logic [7:0] d1, d8, es;
        logic [ID_W-1:0] i1, i8;
        lat1 = 0; lat8 = 0; d1 = '0; d8 = '0; i1 = '0; i8 = '0;
        @(negedge clk);
        s_start = 1'b1;
        s_kp_id = 16'h0808;
        exp_s_q.push_back(8'b0010_0000);
        @(posedge clk);
        #1 s_start = 1'b0;
        n = 0;
        while (n < 40 && (lat1 == 0 || lat8 == 0)) begin
            @(posedge clk);
            #1 n++;
            if (s1_valid && lat1 == 0) begin lat1 = n; d1 = s1_desc; i1 = s1_desc_id; end
            if (s8_valid && lat8 == 0) begin lat8 = n; d8 = s8_desc; i8 = s8_desc_id; end
        end
        es = exp_s_q.pop_front();
        total++;
        if (lat1 != 11 || d1 !== es || i1 !== 16'h0808) begin
            bad++; $display("FAIL lanes1: lat %0d desc %b id %h want lat 11 desc %b id 0808", lat1, d1, i1, es);
        end
        total++;
        if (lat8 != 4 || d8 !== es || i8 !== 16'h0808) begin
            bad++; $display("FAIL lanes8: lat %0d desc %b id %h want lat 4 desc %b id 0808", lat8, d8, i8, es);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        start = 1'b0; abort = 1'b0; desc_ready = 1'b0; kp_id = '0;
        s_start = 1'b0; s_abort = 1'b0; s_ready = 1'b1; s_kp_id = '0;
        test_reset();
        test_ramp();
        test_const();
        test_random();
        test_stall();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_small_lanes();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
